// File: rtl/ar_ctrl_if.sv
// ar_ctrl_if: signal bundle between the timing/decoder logic and the
// address-register unit.
//
// There is no valid/ready handshake on this bundle. Every control input is
// sampled on each rising clock edge, and stall=1 freezes the register for
// that edge. LD/CLR/INC are combinational decodes of the current inputs.
//
//   master modport (timing/decoder side)
//     drives : T, D, J, R, stall, bus_in, clr_err
//     reads  : ar_q, LD, CLR, INC, wrap, err
//   slave modport (ar_ctrl_unit)
//     the reverse of the master modport
interface ar_ctrl_if #(
  parameter int AW = 12,
  parameter int NT = 8
);
  logic [NT-1:0] T;
  logic [7:0]    D;
  logic          J;
  logic          R;
  logic          stall;
  logic [AW-1:0] bus_in;
  logic          clr_err;
  logic [AW-1:0] ar_q;
  logic          LD;
  logic          CLR;
  logic          INC;
  logic          wrap;
  logic          err;

  modport master (
    output T, D, J, R, stall, bus_in, clr_err,
    input  ar_q, LD, CLR, INC, wrap, err
  );

  modport slave (
    input  T, D, J, R, stall, bus_in, clr_err,
    output ar_q, LD, CLR, INC, wrap, err
  );
endinterface

// File: rtl/ar_ctrl_unit.sv
// ar_ctrl_unit: address register (AR) of the basic-computer datapath,
// together with its load/clear/increment decode.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; clears ar_q, wrap and err
//   bus    : ar_ctrl_if.slave
//            inputs  T (one-hot timing), D (decoded opcode), J (I flip-flop),
//                    R (interrupt cycle), stall, bus_in, clr_err
//            outputs ar_q, LD/CLR/INC (combinational decode),
//                    wrap (one-cycle pulse after an increment rollover),
//                    err (sticky control-conflict flag)
//
// Build option
//   AR_CONFLICT_CHK_EN : when defined, builds the checker that sets err on
//   any unstalled edge with two or more of CLR/LD/INC active. When it is
//   undefined, err is tied low and clr_err is ignored.
//
// The timing vector must provide at least T0..T4, so NT >= 5.
module ar_ctrl_unit #(
  parameter int AW = 12,
  parameter int NT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  ar_ctrl_if.slave   bus
);

  logic          ld;
  logic          clr;
  logic          inc;
  logic [AW-1:0] ar_r;
  logic          wrap_r;

  // Control decode
  always_comb begin
    ld  = (~bus.R & bus.T[0]) | (~bus.R & bus.T[2]) |
          (~bus.D[7] & bus.J & bus.T[3]);
    clr = bus.R & bus.T[0];
    inc = bus.D[5] & bus.T[4];
  end

  assign bus.LD  = ld;
  assign bus.CLR = clr;
  assign bus.INC = inc;

  // The address register. CLR has priority over LD, and LD has priority
  // over INC, so a non-one-hot T still gives a deterministic result.
  // wrap defaults low, so it is high only for the single cycle that follows
  // an increment from all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_r   <= '0;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (!bus.stall) begin
        if (clr) begin
          ar_r <= '0;
        end else if (ld) begin
          ar_r <= bus.bus_in;
        end else if (inc) begin
          ar_r   <= ar_r + 1'b1;
          wrap_r <= &ar_r;
        end
      end
    end
  end

  assign bus.ar_q = ar_r;
  assign bus.wrap = wrap_r;

`ifdef AR_CONFLICT_CHK_EN
  logic conflict;
  logic err_r;

  assign conflict = (clr & ld) | (clr & inc) | (ld & inc);

  // If a new conflict and clr_err arrive on the same edge, the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (!bus.stall && conflict) begin
      err_r <= 1'b1;
    end else if (bus.clr_err) begin
      err_r <= 1'b0;
    end
  end

  assign bus.err = err_r;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.err = 1'b0;
`endif

  // Only some of the opcode and timing bits drive the decode.
  logic unused_bits;
  assign unused_bits = ^{bus.D, bus.T};

endmodule

// File: tb/tb_ar_ctrl_unit.sv
// tb_ar_ctrl_unit: directed and random stimulus for ar_ctrl_unit. Expected
// register contents are pushed into a queue when a step is driven, then
// popped and compared once the clock edge has taken effect.
module tb_ar_ctrl_unit;
  localparam int AW = 12;
  localparam int NT = 8;

  localparam logic [NT-1:0] T0 = 8'h01;
  localparam logic [NT-1:0] T1 = 8'h02;
  localparam logic [NT-1:0] T2 = 8'h04;
  localparam logic [NT-1:0] T3 = 8'h08;
  localparam logic [NT-1:0] T4 = 8'h10;
  localparam logic [7:0]    D5 = 8'h20;
  localparam logic [7:0]    D7 = 8'h80;

  logic clk;
  logic rst_n;

  ar_ctrl_if #(.AW(AW), .NT(NT)) bus ();

  ar_ctrl_unit #(.AW(AW), .NT(NT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: observed no-finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic          exp_wrap_q[$];
  logic          exp_err_q[$];
  logic [AW-1:0] m_ar;
  logic          m_err;
  int            nvec;
  int            nfail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One step begins just after a falling edge. It drives the inputs, checks
  // the combinational decode, predicts the register, lets one rising edge
  // occur, and then checks the result at the next falling edge.
  task automatic step(input logic [NT-1:0] t, input logic [7:0] d, input logic j,
                      input logic r, input logic st, input logic [AW-1:0] bi,
                      input logic ce);
    logic e_ld, e_clr, e_inc, e_wrap, e_err;
    logic [AW-1:0] e_ar;
    logic [AW-1:0] got_ar;
    logic got_wrap, got_err;
    bus.T = t; bus.D = d; bus.J = j; bus.R = r;
    bus.stall = st; bus.bus_in = bi; bus.clr_err = ce;
    #1;
    e_ld  = (!r && (t[0] || t[2])) || (!d[7] && j && t[3]);
    e_clr = r && t[0];
    e_inc = d[5] && t[4];
    chk("LD", {31'b0, bus.LD}, {31'b0, e_ld});
    chk("CLR", {31'b0, bus.CLR}, {31'b0, e_clr});
    chk("INC", {31'b0, bus.INC}, {31'b0, e_inc});
    e_ar = m_ar;
    e_wrap = 1'b0;
    if (!st) begin
      if (e_clr) e_ar = '0;
      else if (e_ld) e_ar = bi;
      else if (e_inc) begin
        e_ar = m_ar + 12'd1;
        e_wrap = (m_ar == 12'hFFF);
      end
    end
    e_err = 1'b0;
`ifdef AR_CONFLICT_CHK_EN
    e_err = m_err;
    if (!st && ((e_clr && e_ld) || (e_clr && e_inc) || (e_ld && e_inc))) e_err = 1'b1;
    else if (ce) e_err = 1'b0;
`endif
    exp_q.push_back(e_ar);
    exp_wrap_q.push_back(e_wrap);
    exp_err_q.push_back(e_err);
    @(posedge clk);
    @(negedge clk);
    got_ar = bus.ar_q;
    got_wrap = bus.wrap;
    got_err = bus.err;
    m_ar = exp_q.pop_front();
    m_err = exp_err_q.pop_front();
    chk("ar_q", {20'b0, got_ar}, {20'b0, m_ar});
    chk("wrap", {31'b0, got_wrap}, {31'b0, exp_wrap_q.pop_front()});
    chk("err", {31'b0, got_err}, {31'b0, m_err});
  endtask

  task automatic idle();
    step(T1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nvec = 0; nfail = 0;
    m_ar = '0; m_err = 1'b0;
    rst_n = 1'b0;
    bus.T = T0; bus.D = 8'h00; bus.J = 1'b0; bus.R = 1'b0;
    bus.stall = 1'b0; bus.bus_in = 12'hABC; bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    // Decode stays live while reset is held; the register does not load.
    chk("rst_ar_q", {20'b0, bus.ar_q}, 32'h0);
    chk("rst_wrap", {31'b0, bus.wrap}, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_LD", {31'b0, bus.LD}, 32'h1);
    rst_n = 1'b1;

    // Fetch load at T0, then the T2 load.
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h3A5, 1'b0);
    chk("fetch_const", {20'b0, bus.ar_q}, 32'h3A5);
    step(T2, 8'h00, 1'b0, 1'b0, 1'b0, 12'h2C4, 1'b0);

    // Indirect load at T3: loads only when D7=0 and J=1.
    step(T3, 8'h00, 1'b1, 1'b0, 1'b0, 12'h123, 1'b0);
    chk("ind_const", {20'b0, bus.ar_q}, 32'h123);
    step(T3, 8'h00, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
    step(T3, D7, 1'b1, 1'b0, 1'b0, 12'h789, 1'b0);
    chk("ind_hold_const", {20'b0, bus.ar_q}, 32'h123);

    // BSA increment that rolls over, then an ordinary increment.
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0);
    step(T4, D5, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    chk("wrap_const", {31'b0, bus.wrap}, 32'h1);
    idle();
    chk("wrap_drop_const", {31'b0, bus.wrap}, 32'h0);
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h010, 1'b0);
    step(T4, D5, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    chk("inc_const", {20'b0, bus.ar_q}, 32'h011);

    // Interrupt-cycle clear takes priority over the bus value.
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h0AB, 1'b0);
    step(T0, 8'h00, 1'b0, 1'b1, 1'b0, 12'h555, 1'b0);
    chk("intclr_const", {20'b0, bus.ar_q}, 32'h000);

    // A T0 load held for three stalled cycles applies once stall drops.
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0);
    repeat (3) step(T0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h777, 1'b0);
    chk("stall_const", {20'b0, bus.ar_q}, 32'h111);
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h777, 1'b0);
    chk("unstall_const", {20'b0, bus.ar_q}, 32'h777);

    // Stalled increment from all-ones: no change, no wrap.
    step(T0, 8'h00, 1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0);
    step(T4, D5, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0);

    // Reset asserted in the middle of a cycle clears the register immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ar_q", {20'b0, bus.ar_q}, 32'h0);
    m_ar = '0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(T2, 8'h00, 1'b0, 1'b0, 1'b0, 12'h5A5, 1'b0);

    // Conflict: T0|T4 with R=1 and D5=1 raises CLR and INC together.
    step(T0 | T4, D5, 1'b0, 1'b1, 1'b0, 12'h3C3, 1'b0);
    chk("conf_ar_const", {20'b0, bus.ar_q}, 32'h0);
    idle();
    step(T1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    // A new conflict on the same edge as clr_err wins over the clear.
    step(T0 | T4, D5, 1'b0, 1'b0, 1'b0, 12'h246, 1'b1);
    step(T1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);

    // Random mix, including non-one-hot T values and stalls.
    for (int i = 0; i < 60; i++) begin
      logic [NT-1:0] t;
      t = NT'(1) << $urandom_range(0, NT - 1);
      if ($urandom_range(0, 3) == 0) t = t | (NT'(1) << $urandom_range(0, 4));
      step(t, 8'(1 << $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           12'($urandom_range(0, 4095)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
